// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 32;

  // Presented on ir_data whenever the prefetch buffer is empty
  localparam logic [INST_W-1:0] NOP_INST = 32'h0;

  // One prefetch buffer slot: fetched word plus the byte address it came from
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO of ifu_entry_t with flush and occupancy count.
// Head is read combinationally; simultaneous push and pop allowed at any occupancy.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  ifu_entry_t             push_data,
  input  logic                   pop,
  input  logic                   flush,
  output ifu_entry_t             head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  ifu_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A full FIFO can still accept a push when the head leaves in the same cycle
  assign do_push = push && ((count_q < CNT_W'(DEPTH)) || do_pop);

  // Pointer and occupancy next-state; flush wins over everything
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: sequential word fetches over req/gnt + rvalid, a prefetch buffer
// of {pc, inst} entries towards decode, and branch redirects that flush the buffer and
// discard responses still in flight.
// Optional build macro IFU_PERF_CNT_EN adds perf_fetch_cnt / perf_flush_cnt outputs.
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ir_valid,
  output logic [INST_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_ready
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  discard_q, discard_d;
  logic              started_q;

  // In-flight PC queue: one entry per granted request not yet answered
  logic [ADDR_W-1:0] pcq_q [DEPTH];
  logic [PTR_W-1:0]  pcq_wr_q, pcq_wr_d;
  logic [PTR_W-1:0]  pcq_rd_q, pcq_rd_d;

  logic              grant, rvalid_ok;
  logic [CNT_W:0]    credit_sum;
  logic              fifo_push, fifo_pop, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  ifu_entry_t        fifo_head, fifo_in;
  logic              unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Requests in flight plus buffered words may never exceed the buffer size, so every
  // response always has a slot. started_q holds req low until the first post-reset edge.
  assign credit_sum = (CNT_W + 1)'(outstanding_q) + (CNT_W + 1)'(fifo_count);
  assign imem_req   = started_q && !redirect_valid && (credit_sum < (CNT_W + 1)'(DEPTH));
  assign imem_addr  = fetch_pc_q;
  assign grant      = imem_req && imem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored
  assign rvalid_ok  = imem_rvalid && (outstanding_q != '0);

  assign fifo_in   = '{pc: pcq_q[pcq_rd_q], inst: imem_rdata};
  assign fifo_push = rvalid_ok && (discard_q == '0) && !redirect_valid;
  assign fifo_pop  = ir_valid && ir_ready;

  assign ir_valid = !fifo_empty;
  assign ir_data  = fifo_empty ? NOP_INST : fifo_head.inst;
  assign ir_pc    = fifo_empty ? '0 : fifo_head.pc;

  // Fetch address, credit, discard and PC-queue next-state
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    discard_d     = discard_q;
    pcq_wr_d      = pcq_wr_q;
    pcq_rd_d      = pcq_rd_q;
    outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(rvalid_ok);
    if (grant) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      pcq_wr_d   = pcq_wr_q + PTR_W'(1);
    end
    // Discarded responses belong to requests whose PCs left the queue at the flush
    if (rvalid_ok && (discard_q != '0)) begin
      discard_d = discard_q - CNT_W'(1);
    end else if (rvalid_ok) begin
      pcq_rd_d = pcq_rd_q + PTR_W'(1);
    end
    // imem_req is low here, so no grant can coincide with a redirect
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
      discard_d  = outstanding_q - CNT_W'(rvalid_ok);
      pcq_wr_d   = '0;
      pcq_rd_d   = '0;
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      pcq_wr_q      <= '0;
      pcq_rd_q      <= '0;
      started_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      pcq_wr_q      <= pcq_wr_d;
      pcq_rd_q      <= pcq_rd_d;
      started_q     <= 1'b1;
    end
  end

  // PC queue storage, written with the address of each granted request
  always_ff @(posedge clk) begin
    if (grant) pcq_q[pcq_wr_q] <= fetch_pc_q;
  end

  ifu_fifo #(
    .DEPTH (DEPTH)
  ) u_prefetch (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef IFU_PERF_CNT_EN
  // Event counters: decode transfers and redirects, free-running and wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (fifo_pop)       perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (redirect_valid) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`else
  // Without the perf option transfers and redirects are not tallied.
`endif

  // Memory must not answer when nothing is outstanding
  rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (reset) !(imem_rvalid && (outstanding_q == '0))
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit with a fixed-latency in-order memory model.
// Memory word at byte address a is a ^ 32'hDEAD_0000.
module tb_inst_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ir_valid;
  logic [31:0] ir_data;
  logic [31:0] ir_pc;
  logic        ir_ready;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  inst_fetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ir_valid       (ir_valid),
    .ir_data        (ir_data),
    .ir_pc          (ir_pc),
    .ir_ready       (ir_ready)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t pq[$];
  int    cyc    = 0;
  int    lat    = 1;
  int    grants = 0;
  int    tests  = 0;
  int    failed = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: record handshakes seen before the edge, then drive the next response
  task automatic step();
    logic        g;
    logic        rv;
    logic [31:0] a;
    #1;
    g  = imem_req & imem_gnt;
    rv = imem_rvalid;
    a  = imem_addr;
    @(posedge clk);
    if (rv && pq.size() > 0) void'(pq.pop_front());
    if (g) begin
      pq.push_back('{addr: a, due: cyc + lat});
      grants++;
    end
    cyc++;
    #1;
    if (pq.size() > 0 && pq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_at(pq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hBAD0_BAD0;
    end
  endtask

  task automatic do_reset(input int latency);
    reset          = 1'b1;
    imem_gnt       = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'hBAD0_BAD0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    ir_ready       = 1'b1;
    pq.delete();
    lat    = latency;
    grants = 0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Wait (bounded) for the first word on ir_*; it must be the expected PC and its word
  task automatic scan_first(input string tag, input logic [31:0] exp_pc, input int bound);
    bit found = 0;
    for (int i = 0; i < bound && !found; i++) begin
      step();
      if (ir_valid) begin
        found = 1;
        check({tag, "_pc"}, ir_pc, exp_pc);
        check({tag, "_data"}, ir_data, word_at(exp_pc));
      end
    end
    check({tag, "_found"}, 32'(found), 32'd1);
  endtask

  initial begin
    reset          = 1'b1;
    imem_gnt       = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'hBAD0_BAD0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    ir_ready       = 1'b1;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_ir_data", ir_data, 32'h0);
    check("rst_ir_pc", ir_pc, 32'h0);

    // 1: streaming, 1-cycle memory, decode always ready
    do_reset(1);
    #1;
    check("t1_req_pre_edge", 32'(imem_req), 32'd0);
    check("t1_addr_pre_edge", imem_addr, 32'h0);
    step();
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      check("t1_valid", 32'(ir_valid), 32'd1);
      check("t1_pc", ir_pc, 32'(4 * k));
      check("t1_data", ir_data, word_at(32'(4 * k)));
      step();
    end

    // 2: decode stalled; exactly DEPTH grants then req drops
    do_reset(1);
    ir_ready = 1'b0;
    for (int k = 0; k < 10; k++) step();
    check("t2_grants", 32'(grants), 32'd4);
    check("t2_req", 32'(imem_req), 32'd0);
    check("t2_addr", imem_addr, 32'h10);
    check("t2_valid", 32'(ir_valid), 32'd1);
    check("t2_pc", ir_pc, 32'h0);
    ir_ready = 1'b1;
    step();
    check("t2_drain1", ir_pc, 32'h4);
    step();
    check("t2_drain2", ir_pc, 32'h8);
    step();
    check("t2_drain3", ir_pc, 32'hC);

    // 3: three requests in flight on a 3-cycle memory, redirect to unaligned 0x103
    do_reset(3);
    for (int k = 0; k < 4; k++) step();
    check("t3_inflight", 32'(pq.size()), 32'd3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    check("t3_req_redirect", 32'(imem_req), 32'd0);
    step();
    redirect_valid = 1'b0;
    check("t3_addr", imem_addr, 32'h100);
    check("t3_valid_after", 32'(ir_valid), 32'd0);
    scan_first("t3_first", 32'h100, 20);

    // 4: redirect with rvalid and an ir transfer in the same cycle
    do_reset(1);
    for (int k = 0; k < 4; k++) step();
    check("t4_pc_before", ir_pc, 32'h4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    #1;
    check("t4_req_redirect", 32'(imem_req), 32'd0);
    check("t4_valid_redirect", 32'(ir_valid), 32'd1);
    step();
    redirect_valid = 1'b0;
    check("t4_valid_after", 32'(ir_valid), 32'd0);
    check("t4_addr", imem_addr, 32'h200);
    scan_first("t4_first", 32'h200, 10);

    // 5: fetch address wraps past the top of memory
    do_reset(1);
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    scan_first("t5_first", 32'hFFFF_FFF8, 10);
    step();
    check("t5_pc_fc", ir_pc, 32'hFFFF_FFFC);
    check("t5_data_fc", ir_data, word_at(32'hFFFF_FFFC));
    step();
    check("t5_pc_wrap", ir_pc, 32'h0);
    check("t5_data_wrap", ir_data, word_at(32'h0));

    // 6: reset mid-stream with two requests outstanding; late responses arrive under reset
    do_reset(2);
    for (int k = 0; k < 5; k++) step();
    check("t6_outstanding", 32'(pq.size()), 32'd2);
    check("t6_valid_before", 32'(ir_valid), 32'd1);
    reset = 1'b1;
    pq.delete();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    #1;
    check("t6_valid_rst", 32'(ir_valid), 32'd0);
    check("t6_addr_rst", imem_addr, 32'h0);
    check("t6_req_rst", 32'(imem_req), 32'd0);
`ifdef IFU_PERF_CNT_EN
    check("t6_perf_fetch", perf_fetch_cnt, 32'h0);
    check("t6_perf_flush", perf_flush_cnt, 32'h0);
`endif
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check("t6_valid_late", 32'(ir_valid), 32'd0);
    end
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hBAD0_BAD0;
    reset       = 1'b0;
    #1;
    check("t6_req_release", 32'(imem_req), 32'd0);
    check("t6_addr_release", imem_addr, 32'h0);
    scan_first("t6_first", 32'h0, 10);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
